// File: rtl/mx_fp6_pkg.sv
// Shared MX FP6 (E2M3) / E8M0 types and constants used by the MX datapath stages.
package mx_fp6_pkg;

  localparam int          FP6_FIX_W    = 8;
  localparam int          FP6_EXP_BIAS = 1;
  localparam logic [7:0]  E8M0_NAN     = 8'hFF;

  typedef struct packed {
    logic       sign;
    logic [1:0] exp;
    logic [2:0] man;
  } fp6_t;

  typedef logic [7:0] e8m0_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/fp6_to_fixed.sv
// Combinational, exact FP6 (E2M3) to signed fixed-point decoder; LSB = 2^-3.
module fp6_to_fixed
  import mx_fp6_pkg::*;
(
  input  logic [5:0]                  fp6_i,
  output logic signed [FP6_FIX_W-1:0] fix_o
);

  fp6_t                 fp6_s;
  logic [FP6_FIX_W-1:0] mag_s;

  assign fp6_s = fp6_t'(fp6_i);

  // Subnormals keep the bare mantissa; normals add the hidden bit and shift.
  always_comb begin
    mag_s = 8'd0;
    if (fp6_s.exp == 2'd0) begin
      mag_s = {5'd0, fp6_s.man};
    end else begin
      mag_s = {4'd0, 1'b1, fp6_s.man} << (fp6_s.exp - 2'(FP6_EXP_BIAS));
    end
    if (fp6_s.sign) begin
      fix_o = -$signed(mag_s);
    end else begin
      fix_o = $signed(mag_s);
    end
  end

endmodule

// File: rtl/mx_fp6_block_accumulator.sv
// Two-stage FP6 block accumulator with E8M0 scale capture and valid/ready result hold.
// Optional MX_ACC_SAT_EN: saturating additions plus an out_sat flag port.
module mx_fp6_block_accumulator
  import mx_fp6_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [5:0]                     in_data,
  input  logic [7:0]                     in_scale,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_W-1:0]        out_acc,
  output logic [7:0]                     out_scale,
  output logic [$clog2(MAX_LEN+1)-1:0]   out_count,
  output logic                           out_nan,
  output logic                           out_overrun
`ifdef MX_ACC_SAT_EN
  ,
  output logic                           out_sat
`endif
);

  localparam int CNT_W = $clog2(MAX_LEN+1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [FP6_FIX_W-1:0] fix_s;
  acc_state_t                  state_q;
  logic                        in_ready_q, first_q, out_valid_q;
  logic                        s1_valid_q, s1_last_q, s1_first_q, s1_ovr_q;
  logic signed [FP6_FIX_W-1:0] s1_fix_q;
  e8m0_t                       s1_scale_q, scale_q;
  logic signed [ACC_W-1:0]     acc_q, sum_d;
  logic [CNT_W-1:0]            cnt_q;
  logic                        nan_q, ovr_q;
  logic                        take_s, hit_max_s, close_s;
`ifdef MX_ACC_SAT_EN
  logic                        sat_q, sat_hit_s;
  logic signed [ACC_W:0]       wide_s;
`endif

  fp6_to_fixed u_dec (
    .fp6_i (in_data),
    .fix_o (fix_s)
  );

  assign take_s    = in_valid & in_ready_q;
  assign hit_max_s = (cnt_q == CNT_W'(MAX_LEN - 1));
  assign close_s   = in_last | hit_max_s;

  // S2 next sum: the first element of a block loads instead of adding.
  always_comb begin
    sum_d = ACC_W'(s1_fix_q);
`ifdef MX_ACC_SAT_EN
    wide_s    = '0;
    sat_hit_s = 1'b0;
    if (!s1_first_q) begin
      wide_s = (ACC_W+1)'(acc_q) + (ACC_W+1)'(s1_fix_q);
      if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
        sat_hit_s = 1'b1;
        sum_d     = wide_s[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        sum_d = wide_s[ACC_W-1:0];
      end
    end else begin
      sat_hit_s = 1'b0;
    end
`else
    if (!s1_first_q) begin
      sum_d = acc_q + ACC_W'(s1_fix_q);
    end else begin
      sum_d = ACC_W'(s1_fix_q);
    end
`endif
  end

  // Control FSM, S1 capture and S2 accumulation with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      in_ready_q  <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_ovr_q    <= 1'b0;
      s1_fix_q    <= 8'sd0;
      s1_scale_q  <= 8'd0;
      acc_q       <= '0;
      cnt_q       <= '0;
      scale_q     <= 8'd0;
      nan_q       <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef MX_ACC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q <= take_s;
      if (take_s) begin
        s1_fix_q   <= fix_s;
        s1_last_q  <= close_s;
        s1_first_q <= first_q;
        s1_scale_q <= in_scale;
        s1_ovr_q   <= hit_max_s & ~in_last;
        cnt_q      <= cnt_q + CNT_W'(1);
        first_q    <= 1'b0;
      end
      case (state_q)
        ST_ACCUM: begin
          // Stop accepting from the cycle after the closing element until release.
          in_ready_q <= ~(take_s & close_s) & ~(s1_valid_q & s1_last_q);
          if (s1_valid_q) begin
            acc_q <= sum_d;
            if (s1_first_q) begin
              scale_q <= s1_scale_q;
              nan_q   <= (s1_scale_q == E8M0_NAN);
`ifdef MX_ACC_SAT_EN
              sat_q   <= sat_hit_s;
`endif
            end else begin
`ifdef MX_ACC_SAT_EN
              sat_q   <= sat_q | sat_hit_s;
`endif
            end
            if (s1_last_q) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
              ovr_q       <= s1_ovr_q;
            end
          end
        end
        ST_HOLD: begin
          in_ready_q <= out_ready;
          if (out_ready) begin
            state_q     <= ST_ACCUM;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            first_q     <= 1'b1;
`ifdef MX_ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_acc     = acc_q;
  assign out_scale   = scale_q;
  assign out_count   = cnt_q;
  assign out_nan     = nan_q;
  assign out_overrun = ovr_q;
`ifdef MX_ACC_SAT_EN
  assign out_sat     = sat_q;
`endif

endmodule

// File: tb/tb_mx_fp6_block_accumulator.sv
// Self-checking bench for mx_fp6_block_accumulator: decode table, directed corners, random stream vs model.
module tb_mx_fp6_block_accumulator;

  localparam int ACC_W   = 16;
  localparam int MAX_LEN = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        in_data = 6'd0;
  logic [7:0]        in_scale = 8'd0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [15:0] out_acc;
  logic [7:0]        out_scale;
  logic [5:0]        out_count;
  logic              out_nan;
  logic              out_overrun;
`ifdef MX_ACC_SAT_EN
  logic              out_sat;
`endif

  mx_fp6_block_accumulator #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_scale    (in_scale),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .out_scale   (out_scale),
    .out_count   (out_count),
    .out_nan     (out_nan),
    .out_overrun (out_overrun)
`ifdef MX_ACC_SAT_EN
    ,
    .out_sat     (out_sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int cnt;
    int scale;
    int nan;
    int ovr;
  } res_t;

  typedef struct {
    logic [5:0] d;
    logic [7:0] s;
    int         acc;
  } vec_t;

  res_t expq[$];
  res_t cur;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hold_len = 0;
  bit   early_rdy = 1'b0;
  bit   holding = 1'b0;
  int   wait_left = 0;
  int   hs_edge = 0;
  int   acc_edge = 0;
  int   m_cnt = 0;
  int   m_sum = 0;
  int   m_scale = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dec(input logic [5:0] d);
    int m, e, mag;
    m   = int'(d[2:0]);
    e   = int'(d[4:3]);
    mag = (e == 0) ? m : (8 + m) * (1 << (e - 1));
    return d[5] ? -mag : mag;
  endfunction

  // Reference model: closes a block on last or when MAX_LEN elements are in.
  task automatic feed(input logic [5:0] d, input logic [7:0] s, input logic l);
    res_t r;
    logic signed [15:0] w;
    if (m_cnt == 0) begin
      m_sum   = 0;
      m_scale = int'(s);
    end
    m_sum += dec(d);
    m_cnt++;
    if (l || m_cnt == MAX_LEN) begin
      w       = m_sum[15:0];
      r.acc   = int'(w);
      r.cnt   = m_cnt;
      r.scale = m_scale;
      r.nan   = (m_scale == 255) ? 1 : 0;
      r.ovr   = l ? 0 : 1;
      expq.push_back(r);
      m_cnt = 0;
    end
  endtask

  task automatic expect_res(input int acc, input int cnt, input int scale, input int ovr);
    res_t r;
    r.acc = acc; r.cnt = cnt; r.scale = scale; r.nan = (scale == 255) ? 1 : 0; r.ovr = ovr;
    expq.push_back(r);
  endtask

  // Called at a negedge; returns at the negedge after the element is accepted.
  task automatic send(input logic [5:0] d, input logic [7:0] s, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_scale = s; in_last = l;
    while (in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("accept_timeout", 0, 1);
    acc_edge = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Output collector: checks each result against the expected queue and handles out_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        holding   = 1'b0;
        out_ready = 1'b0;
      end else if (holding && out_ready) begin
        chk("hs_valid_drop", int'(out_valid), 0);
        chk("hs_in_ready", int'(in_ready), 1);
        holding   = 1'b0;
        out_ready = early_rdy;
      end else if (holding) begin
        chk("hold_acc", int'(out_acc), cur.acc);
        chk("hold_count", int'(out_count), cur.cnt);
        chk("hold_scale", int'(out_scale), cur.scale);
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_in_ready", int'(in_ready), 0);
        if (wait_left == 0) begin
          out_ready = 1'b1;
          hs_edge   = cyc + 1;
        end else begin
          wait_left--;
        end
      end else if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_result", 1, 0);
          cur.acc = 0; cur.cnt = 0; cur.scale = 0; cur.nan = 0; cur.ovr = 0;
        end else begin
          cur = expq.pop_front();
        end
        chk("res_acc", int'(out_acc), cur.acc);
        chk("res_count", int'(out_count), cur.cnt);
        chk("res_scale", int'(out_scale), cur.scale);
        chk("res_nan", int'(out_nan), cur.nan);
        chk("res_overrun", int'(out_overrun), cur.ovr);
        chk("res_in_ready", int'(in_ready), 0);
        holding = 1'b1;
        if (hold_len == 0) begin
          out_ready = 1'b1;
          hs_edge   = cyc + 1;
        end else begin
          out_ready = 1'b0;
          wait_left = hold_len - 1;
        end
      end else begin
        out_ready = early_rdy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int   n;
    tbl[0]  = '{6'h00, 8'h01, 0};
    tbl[1]  = '{6'h20, 8'h02, 0};
    tbl[2]  = '{6'h07, 8'h7F, 7};
    tbl[3]  = '{6'h27, 8'h80, -7};
    tbl[4]  = '{6'h08, 8'h03, 8};
    tbl[5]  = '{6'h1F, 8'hFF, 60};
    tbl[6]  = '{6'h3F, 8'h10, -60};
    tbl[7]  = '{6'h10, 8'h11, 16};
    tbl[8]  = '{6'h18, 8'h12, 32};
    tbl[9]  = '{6'h0F, 8'h13, 15};
    tbl[10] = '{6'h2A, 8'h14, -10};
    tbl[11] = '{6'h17, 8'h15, 30};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    chk("rst_out_scale", int'(out_scale), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_nan", int'(out_nan), 0);
    chk("rst_out_overrun", int'(out_overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-element blocks from the decode table
    for (int i = 0; i < 12; i++) begin
      expect_res(tbl[i].acc, 1, int'(tbl[i].s), 0);
      send(tbl[i].d, tbl[i].s, 1'b1);
    end

    // Four 1.0 products, latency and a 5-cycle stalled output
    hold_len = 5;
    expect_res(32, 4, 8'h7F, 0);
    for (int i = 0; i < 4; i++) send(6'h08, 8'h7F, (i == 3) ? 1'b1 : 1'b0);
    chk("lat_t1_not_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_t2_valid", int'(out_valid), 1);

    // Mixed block right after the stalled handshake; must not include the prior sum
    expect_res(53, 3, 8'h80, 0);
    send(6'h1F, 8'h80, 1'b0);
    chk("next_accept_edge", acc_edge, hs_edge + 1);
    hold_len = 0;
    send(6'h01, 8'h00, 1'b0);
    send(6'h28, 8'h00, 1'b1);

    // 40 elements with no last: force-close at MAX_LEN, then the tail block
    expect_res(1920, 32, 8'h10, 1);
    expect_res(540, 9, 8'h10, 0);
    for (int i = 0; i < 40; i++) send(6'h1F, 8'h10, 1'b0);
    send(6'h1F, 8'h10, 1'b1);

    // NaN scale captured from the first element only
    expect_res(16, 2, 8'hFF, 0);
    send(6'h08, 8'hFF, 1'b0);
    send(6'h08, 8'h00, 1'b1);

    // Reset mid-block discards the partial sum
    n = 0;
    while (expq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) send(6'h08, 8'h33, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_count", int'(out_count), 0);
    chk("midrst_acc", int'(out_acc), 0);
    rst = 1'b0;
    @(negedge clk);
    expect_res(16, 1, 8'h42, 0);
    send(6'h10, 8'h42, 1'b1);

    // Random stream against the reference model, random stalls and early ready
    for (int i = 0; i < 150; i++) begin
      logic [5:0] d;
      logic [7:0] s;
      logic       l;
      d = 6'($urandom_range(0, 63));
      s = 8'($urandom_range(0, 255));
      l = ($urandom_range(0, 7) == 0) || (i == 149);
      hold_len  = $urandom_range(0, 3);
      early_rdy = ($urandom_range(0, 1) == 1);
      feed(d, s, l);
      send(d, s, l);
    end

    n = 0;
    while ((expq.size() != 0 || holding) && n < 500) begin @(negedge clk); n++; end
    chk("drain_pending", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mx_fp6_block_accumulator.md
Name: mx_fp6_block_accumulator

Overview:
- Downstream consumer of the FP6 (E2M3) multiplier array.
- Accepts a valid/ready stream of FP6 products belonging to one MX block and converts each product to exact signed fixed point (LSB = 2^-3).
- Accumulates the products and captures the block's shared E8M0 scale.
- Emits one accumulated result per block, with flags, over a valid/ready output handshake.

Parameters:
- ACC_W, 16, signed accumulator and result width; must be >= 8 + clog2(MAX_LEN).
- MAX_LEN, 32, maximum number of elements in one block; element counter width is clog2(MAX_LEN+1).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  product valid.
- in_ready  output  1  accumulator can accept a product this cycle.
- in_data  input  6  FP6 product: [5] sign, [4:3] exponent (bias 1), [2:0] mantissa.
- in_scale  input  8  E8M0 shared block scale; sampled only on the first accepted element of a block.
- in_last  input  1  final element of the block.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  signed sum; LSB = 2^-3.
- out_scale  output  8  captured E8M0 scale.
- out_count  output  clog2(MAX_LEN+1)  number of elements accumulated.
- out_nan  output  1  captured scale == 8'hFF.
- out_overrun  output  1  block was force-closed at MAX_LEN without in_last.

Behaviour:
- Decode (combinational, exact), with m = in_data[2:0] and e = in_data[4:3]:
  - e == 0: magnitude = m.
  - e != 0: magnitude = (8 + m) << (e - 1).
  - Magnitude range is 0..60. Apply the sign by two's complement; -0 decodes to 0.
- Pipeline: stage S1 registers {fixed, last, first, scale}; stage S2 is the accumulator.
- Latency: the last element accepted in cycle t produces out_valid=1 in cycle t+2.
- FSM state ACCUM:
  - in_ready = 1.
  - Each accepted element (in_valid & in_ready) flows through S1 and is added in S2; the counter increments.
  - The first element of a block loads the accumulator (no add to a stale value) and captures in_scale.
  - After in_last is accepted, in_ready drops to 0 in the following cycle; once S2 absorbs the last element, go to HOLD.
- Force-close: if the counter reaches MAX_LEN on an element without in_last, treat that element as last and set overrun.
- FSM state HOLD:
  - out_valid = 1; all out_* fields are stable and in_ready = 0.
  - On out_ready = 1: clear out_valid, the accumulator and the counter, then return to ACCUM; in_ready = 1 in the next cycle.
  - out_ready asserted before out_valid has no effect.
- A block of exactly one element (first and last together) is legal: result = that element.
- Overflow without MX_ACC_SAT_EN: two's-complement wrap.
- Reset mid-block: the partial block is discarded with no output.
- Reset values: out_valid=0, out_acc=0, out_scale=0, out_count=0, out_nan=0, out_overrun=0, in_ready=0 while rst is high, state=ACCUM.

Optional Feature:
- Macro: MX_ACC_SAT_EN.
- Defined: each addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and an extra output port out_sat (1 bit, reset 0) is set for the block if any clamp occurred.
- Undefined: additions wrap and the out_sat port does not exist.

Decomposition:
- Package mx_fp6_pkg:
  - typedef fp6_t (packed sign/exp/man struct) and typedef e8m0_t.
  - Constants FP6_FIX_W = 8, FP6_EXP_BIAS = 1, E8M0_NAN = 8'hFF.
- Sub-module fp6_to_fixed: combinational FP6 to signed 8-bit decoder, reusable by other MX stages.

Test Plan:
- Block {0x08, 0x08, 0x08, 0x08} with last on the 4th and scale 0x7F -> out_acc=32, out_count=4, out_scale=0x7F, out_nan=0, out_valid two cycles after last.
- Mixed block {0x1F (7.5), 0x01 (0.125), 0x28 (-1.0)} -> out_acc = 60 + 1 - 8 = 53.
- out_ready held low for 5 cycles -> in_ready=0 and outputs stable throughout; the next block's first element is accepted the cycle after the handshake, and its result excludes the prior sum.
- 40 elements of 0x1F, never last, MAX_LEN=32 -> result after 32 elements: out_acc=1920, out_count=32, out_overrun=1.
- Scale 0xFF on the first element (0x00 on later elements) -> out_nan=1 and out_scale=0xFF.
- rst pulsed after 3 elements, then a single-element block {0x10 (2.0)} -> out_acc=16, out_count=1.
